// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage; drives the data-bus handshake and aligns/extends load/store data.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag out_exc.
//
// state | meaning
// EMPTY | no instruction held, ready to accept
// REQ   | request presented, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | result presented on out_* for this cycle, ready to accept
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int DBUS_W = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_alu_out,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [1:0]            in_msize,
    input  logic                  in_unsigned,
    input  logic [4:0]            in_dst,
    input  logic                  in_regwrite,
    input  logic [1:0]            in_wbsel,
    output logic                  dreq_valid,
    output logic [XLEN-1:0]       dreq_addr,
    output logic [2:0]            dreq_size,
    output logic [DBUS_W/8-1:0]   dreq_strobe,
    output logic [DBUS_W-1:0]     dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DBUS_W-1:0]     dresp_data,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_alu_out,
    output logic [XLEN-1:0]       out_rd,
    output logic [4:0]            out_dst,
    output logic                  out_regwrite,
    output logic [1:0]            out_wbsel,
    output logic                  out_exc
);
    localparam int STRB_W = DBUS_W / 8;

    typedef enum logic [1:0] {EMPTY, REQ, WAIT, DONE} stateT;

    stateT state, nextState;
    logic accept, captureData, isMemIn, trapIn;

    logic [XLEN-1:0] pcQ, aluQ, storeQ;
    logic            readQ, writeQ, unsignedQ, regwriteQ;
    logic [1:0]      msizeQ, wbselQ;
    logic [4:0]      dstQ;

    function automatic logic [XLEN-1:0] extendLoad(input logic [DBUS_W-1:0] raw, input logic [2:0] off,
                                                    input logic [1:0] size, input logic uns);
        logic [DBUS_W-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    return {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
            2'd1:    return {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
            2'd2:    return {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
            default: return sh[XLEN-1:0];
        endcase
    endfunction

    assign isMemIn = in_mem_read | in_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic [2:0] alignMask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    assign trapIn = isMemIn & (|(in_alu_out[2:0] & alignMask(in_msize)));
`else
    assign trapIn = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= EMPTY;
        else         state <= nextState;
    end

    always_comb begin
        nextState   = state;
        accept      = 1'b0;
        captureData = 1'b0;
        in_ready    = 1'b0;
        dreq_valid  = 1'b0;
        out_valid   = 1'b0;
        case (state)
            EMPTY, DONE: begin
                in_ready  = 1'b1;
                out_valid = (state == DONE);
                if (in_valid) begin
                    accept    = 1'b1;
                    nextState = (isMemIn && !trapIn) ? REQ : DONE;
                end else begin
                    nextState = EMPTY;
                end
            end
            REQ: begin
                dreq_valid = 1'b1;
                if (dresp_addr_ok && dresp_data_ok) begin
                    captureData = 1'b1;
                    nextState   = DONE;
                end else if (dresp_addr_ok) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                dreq_valid = 1'b1;
                if (dresp_data_ok) begin
                    captureData = 1'b1;
                    nextState   = DONE;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcQ <= '0; aluQ <= '0; storeQ <= '0;
            readQ <= 1'b0; writeQ <= 1'b0; unsignedQ <= 1'b0; regwriteQ <= 1'b0;
            msizeQ <= '0; wbselQ <= '0; dstQ <= '0;
            out_pc <= '0; out_alu_out <= '0; out_rd <= '0; out_dst <= '0;
            out_regwrite <= 1'b0; out_wbsel <= '0; out_exc <= 1'b0;
        end else begin
            if (accept) begin
                pcQ <= in_pc; aluQ <= in_alu_out; storeQ <= in_store_data;
                readQ <= in_mem_read; writeQ <= in_mem_write; unsignedQ <= in_unsigned;
                regwriteQ <= in_regwrite; msizeQ <= in_msize; wbselQ <= in_wbsel; dstQ <= in_dst;
            end
            // Non-memory and trapped instructions complete straight from the execute inputs.
            if (accept && (!isMemIn || trapIn)) begin
                out_pc <= in_pc; out_alu_out <= in_alu_out; out_rd <= '0; out_dst <= in_dst;
                out_regwrite <= in_regwrite & ~trapIn; out_wbsel <= in_wbsel; out_exc <= trapIn;
            end
            if (captureData) begin
                out_pc <= pcQ; out_alu_out <= aluQ; out_dst <= dstQ;
                out_regwrite <= regwriteQ; out_wbsel <= wbselQ; out_exc <= 1'b0;
                out_rd <= readQ ? extendLoad(dresp_data, aluQ[2:0], msizeQ, unsignedQ) : '0;
            end
        end
    end

    assign dreq_addr   = aluQ;
    assign dreq_size   = {1'b0, msizeQ};
    assign dreq_strobe = writeQ ? STRB_W'(((STRB_W'(1) << (4'(1) << msizeQ)) - STRB_W'(1)) << aluQ[2:0]) : '0;
    assign dreq_data   = writeQ ? DBUS_W'(storeQ) << {aluQ[2:0], 3'b000} : '0;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized checks of mem_stage against a byte-level reference model.
module tb_mem_stage;
    localparam int XLEN = 64, DBUS_W = 64;

    logic clk = 1'b0, resetn = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [XLEN-1:0] in_pc = '0, in_alu_out = '0, in_store_data = '0;
    logic in_mem_read = 1'b0, in_mem_write = 1'b0, in_unsigned = 1'b0, in_regwrite = 1'b0;
    logic [1:0] in_msize = '0, in_wbsel = '0;
    logic [4:0] in_dst = '0;
    logic dreq_valid;
    logic [XLEN-1:0] dreq_addr;
    logic [2:0] dreq_size;
    logic [DBUS_W/8-1:0] dreq_strobe;
    logic [DBUS_W-1:0] dreq_data;
    logic dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
    logic [DBUS_W-1:0] dresp_data = '0;
    logic out_valid, out_regwrite, out_exc;
    logic [XLEN-1:0] out_pc, out_alu_out, out_rd;
    logic [4:0] out_dst;
    logic [1:0] out_wbsel;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(XLEN), .DBUS_W(DBUS_W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_msize(in_msize), .in_unsigned(in_unsigned), .in_dst(in_dst),
        .in_regwrite(in_regwrite), .in_wbsel(in_wbsel), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_alu_out(out_alu_out), .out_rd(out_rd),
        .out_dst(out_dst), .out_regwrite(out_regwrite), .out_wbsel(out_wbsel), .out_exc(out_exc)
    );

    typedef struct {
        logic [63:0] pc, alu, rd;
        logic [4:0]  dst;
        logic        regwrite;
        logic [1:0]  wbsel;
        logic        exc;
    } resT;

    int total = 0, bad = 0;
    resT prevRes = '{64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 1'b0};
    logic expDone = 1'b0;
    bit useForced = 0, litOn = 0;
    logic [63:0] forcedData = '0, litData = '0;
    logic [7:0] litStrobe = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] expStrobe(input logic [2:0] off, input logic [1:0] sz);
        int o = int'(off), n = 1 << sz;
        logic [7:0] s = '0;
        for (int b = 0; b < 8; b++) if (b >= o && b < o + n) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] expStore(input logic [63:0] d, input logic [2:0] off);
        int o = int'(off);
        logic [63:0] r = '0;
        for (int b = 0; b + o < 8; b++) r[8*(b+o) +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] expLoad(input logic [63:0] raw, input logic [2:0] off,
                                            input logic [1:0] sz, input logic uns);
        int o = int'(off), n = 1 << sz;
        logic [63:0] v = '0;
        for (int b = 0; b < n; b++) if (o + b < 8) v[8*b +: 8] = raw[8*(o+b) +: 8];
        if (!uns && n < 8 && v[8*n-1]) for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic checkOut();
        chk("out_valid", 64'(out_valid), 64'(expDone));
        if (expDone) begin
            chk("out_pc", out_pc, prevRes.pc);
            chk("out_alu_out", out_alu_out, prevRes.alu);
            chk("out_rd", out_rd, prevRes.rd);
            chk("out_dst", 64'(out_dst), 64'(prevRes.dst));
            chk("out_regwrite", 64'(out_regwrite), 64'(prevRes.regwrite));
            chk("out_wbsel", 64'(out_wbsel), 64'(prevRes.wbsel));
            chk("out_exc", 64'(out_exc), 64'(prevRes.exc));
        end else begin
            chk("out_pc_hold", out_pc, prevRes.pc);
            chk("out_rd_hold", out_rd, prevRes.rd);
        end
    endtask

    task automatic idle(input bit noise);
        in_valid = 1'b0;
        dresp_addr_ok = noise;
        dresp_data_ok = noise;
        dresp_data = {$urandom, $urandom};
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        chk("dreq_valid_idle", 64'(dreq_valid), 64'd0);
        checkOut();
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        expDone = 1'b0;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. aW = REQ cycles before addr_ok, dW = extra cycles to data_ok.
    task automatic runInstr(input int kind, input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] sd,
                            input logic [1:0] sz, input logic uns, input logic [4:0] dst, input logic rw,
                            input logic [1:0] wb, input int aW, input int dW);
        logic isMem, trap;
        logic [63:0] raw;
        resT r;
        isMem = (kind != 0);
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = isMem && ((alu % (64'd1 << sz)) != 64'd0);
`endif
        raw = '0;
        in_valid = 1'b1; in_pc = pc; in_alu_out = alu; in_store_data = sd;
        in_mem_read = (kind == 1); in_mem_write = (kind == 2); in_msize = sz; in_unsigned = uns;
        in_dst = dst; in_regwrite = rw; in_wbsel = wb;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        #1;
        chk("in_ready_accept", 64'(in_ready), 64'd1);
        chk("dreq_valid_accept", 64'(dreq_valid), 64'd0);
        checkOut();
        tick();
        expDone = 1'b0;
        r = '{pc, alu, 64'd0, dst, rw, wb, 1'b0};
        if (trap) begin
            r.regwrite = 1'b0;
            r.exc = 1'b1;
        end else if (isMem) begin
            for (int c = 0; c <= aW + dW; c++) begin
                dresp_addr_ok = (c == aW) ? 1'b1 : ((c > aW) ? 1'($urandom_range(0, 1)) : 1'b0);
                dresp_data_ok = (c == aW + dW);
                raw = useForced ? forcedData : {$urandom, $urandom};
                dresp_data = raw;
                #1;
                chk("dreq_valid_busy", 64'(dreq_valid), 64'd1);
                chk("in_ready_busy", 64'(in_ready), 64'd0);
                chk("dreq_addr", dreq_addr, alu);
                chk("dreq_size", 64'(dreq_size), 64'({1'b0, sz}));
                chk("dreq_strobe", 64'(dreq_strobe), 64'((kind == 2) ? expStrobe(alu[2:0], sz) : 8'h00));
                if (kind == 2) chk("dreq_data", dreq_data, expStore(sd, alu[2:0]));
                if (litOn) begin
                    chk("lit_strobe", 64'(dreq_strobe), 64'(litStrobe));
                    chk("lit_data", dreq_data, litData);
                end
                checkOut();
                tick();
            end
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            if (kind == 1) r.rd = expLoad(raw, alu[2:0], sz, uns);
        end
        prevRes = r;
        expDone = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_rd", out_rd, 64'd0);
        chk("rst_out_exc", 64'(out_exc), 64'd0);
        chk("rst_dreq_addr", dreq_addr, 64'd0);
        chk("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
        chk("rst_dreq_data", dreq_data, 64'd0);
        #10 resetn = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Signed byte load: byte 3 of the beat is 0x80.
        useForced = 1; forcedData = 64'h00000000_80000000;
        runInstr(1, 64'h100, 64'h1003, 64'd0, 2'd0, 1'b0, 5'd5, 1'b1, 2'd1, 0, 0);
        useForced = 0;
        #1 chk("lb_rd_literal", out_rd, 64'hFFFFFFFF_FFFFFF80);
        idle(0);

        // Word store at offset 4.
        litOn = 1; litStrobe = 8'hF0; litData = 64'hDEADBEEF_00000000;
        runInstr(2, 64'h104, 64'h2004, 64'hDEADBEEF, 2'd2, 1'b0, 5'd0, 1'b0, 2'd0, 0, 0);
        litOn = 0;
        idle(0);

        // Three ALU instructions back-to-back.
        runInstr(0, 64'h200, 64'h11, 64'd0, 2'd0, 1'b0, 5'd1, 1'b1, 2'd0, 0, 0);
        runInstr(0, 64'h204, 64'h22, 64'd0, 2'd0, 1'b0, 5'd2, 1'b1, 2'd0, 0, 0);
        runInstr(0, 64'h208, 64'h33, 64'd0, 2'd0, 1'b0, 5'd3, 1'b1, 2'd0, 0, 0);
        idle(0);

        // Slow bus: addr_ok in the first request cycle, data_ok three cycles later.
        runInstr(1, 64'h300, 64'h4008, 64'd0, 2'd3, 1'b0, 5'd7, 1'b1, 2'd1, 0, 3);
        idle(1);
        idle(1);

`ifdef MEM_MISALIGN_TRAP_EN
        runInstr(1, 64'h400, 64'h3001, 64'd0, 2'd1, 1'b0, 5'd9, 1'b1, 2'd1, 0, 0);
        idle(0);
`endif

        // Randomized mix of ALU, load and store with varied bus latency.
        for (int i = 0; i < 60; i++) begin
            runInstr(int'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle(1'($urandom_range(0, 1)));
        end
        idle(0);

        // Reset while waiting for data.
        in_valid = 1'b1; in_pc = 64'h500; in_alu_out = 64'h5000; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_msize = 2'd3; in_unsigned = 1'b0; in_dst = 5'd4; in_regwrite = 1'b1; in_wbsel = 2'd1;
        tick();
        dresp_addr_ok = 1'b1;
        #1 chk("rstx_req_valid", 64'(dreq_valid), 64'd1);
        tick();
        dresp_addr_ok = 1'b0;
        in_valid = 1'b0;
        #1 chk("rstx_wait_valid", 64'(dreq_valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rstx_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rstx_out_valid", 64'(out_valid), 64'd0);
        tick();
        resetn = 1'b1;
        prevRes = '{64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 1'b0};
        expDone = 1'b0;
        idle(1);
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the RV64 core; sits between execute and writeback.
- Holds one instruction at a time and drives the data-bus request/response handshake for loads and stores.
- Aligns store data and byte strobes on the way out; shifts and sign/zero-extends load data on the way back.
- Presents a registered result to the combinational writeback stage for exactly one cycle per instruction.

Parameters:
- XLEN, 64, datapath and address width.
- DBUS_W, 64, data-bus width; byte strobe is DBUS_W/8 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_alu_out  in  XLEN  ALU result / effective address
- in_store_data  in  XLEN  rs2 value for stores
- in_mem_read  in  1  load
- in_mem_write  in  1  store; never set together with in_mem_read
- in_msize  in  2  0=byte, 1=half, 2=word, 3=dword
- in_unsigned  in  1  zero-extend the load
- in_dst  in  5  destination register
- in_regwrite  in  1  writes the register file
- in_wbsel  in  2  writeback source select, passed through
- dreq_valid  out  1  bus request
- dreq_addr  out  XLEN  request address
- dreq_size  out  3  {1'b0, msize}
- dreq_strobe  out  DBUS_W/8  byte enables; all zero for loads
- dreq_data  out  DBUS_W  aligned store data
- dresp_addr_ok  in  1  address accepted
- dresp_data_ok  in  1  transfer complete
- dresp_data  in  DBUS_W  raw read data
- out_valid  out  1  result valid (one-cycle pulse)
- out_pc, out_alu_out  out  XLEN  registered pass-through
- out_rd  out  XLEN  extended load data; 0 for non-loads
- out_dst  out  5  registered pass-through
- out_regwrite  out  1  registered pass-through
- out_wbsel  out  2  registered pass-through
- out_exc  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (async, resetn=0): state=EMPTY; all out_* and dreq_* outputs 0; in_ready=1 once reset is released.
- States:
  - EMPTY: in_ready=1. Accept when in_valid=1: latch all inputs. If the instruction is a load or store, go to REQ; otherwise go to DONE.
  - REQ: dreq_valid=1.
    - addr_ok=1 and data_ok=1 in the same cycle: capture the data, go to DONE.
    - addr_ok=1 only: go to WAIT.
    - Neither: stay in REQ; request fields stay stable.
  - WAIT: dreq_valid=1 and stable until data_ok=1; then capture the data and go to DONE. An addr_ok seen in WAIT is ignored.
  - DONE: out_valid=1 for exactly this cycle; in_ready=1.
    - Accept in the same cycle (back-to-back): go to REQ or DONE per the new instruction.
    - No accept: go to EMPTY.
- in_ready is 0 in REQ and WAIT; execute stalls on it.
- Latency from accept to out_valid:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: 2 cycles minimum (REQ with addr_ok and data_ok together), plus 1 per additional wait cycle.
- Sustained throughput for non-memory instructions: one per cycle.
- Address and store alignment (off = addr[2:0]):
  - dreq_addr = latched alu_out, unmodified.
  - Store strobe = ((1<<(1<<msize))-1) << off, truncated to 8 bits.
  - dreq_data = store_data << (8*off).
- Load extension: raw = dresp_data >> (8*off); keep the low 8/16/32/64 bits per msize; zero-extend if unsigned, otherwise sign-extend to XLEN.
- out_* fields are registered and hold their values outside the DONE cycle; only out_valid qualifies them.
- out_rd is captured only from a data_ok cycle.
- Boundaries:
  - data_ok asserted without a pending request (EMPTY or DONE): ignored.
  - in_valid while in REQ or WAIT: not accepted; execute must hold its inputs.
  - Reset during REQ or WAIT: dreq_valid drops immediately; the transaction is abandoned.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - On accept, a load/store whose address is not a multiple of (1<<msize) goes directly to DONE without issuing a request.
  - In that DONE cycle: out_exc=1, out_regwrite=0, out_rd=0.
- Undefined: misaligned accesses are issued unchanged; out_exc is tied to 0.

Test Plan:
- Load byte, signed: alu_out=0x1003, msize=0, unsigned=0, dresp_data=0x00000000_80000000 with addr_ok and data_ok in the first REQ cycle -> out_valid 2 cycles after accept, out_rd=0xFFFFFFFFFFFFFF80.
- Store word: alu_out=0x2004, msize=2, store_data=0xDEADBEEF -> dreq_strobe=0xF0, dreq_data=0xDEADBEEF_00000000, dreq_size=3'b010; out_valid one cycle after data_ok.
- Back-to-back non-memory: 3 consecutive ALU instructions with in_valid held high -> in_ready stays 1, out_valid high 3 consecutive cycles, out_pc in order, dreq_valid never asserted.
- Slow bus: load dword with addr_ok at cycle 1 and data_ok at cycle 4 -> REQ→WAIT→DONE; dreq_valid and dreq_addr stable cycles 1–4; in_ready=0 until DONE.
- Reset mid-transaction: resetn=0 while in WAIT -> dreq_valid=0 and out_valid=0 the same cycle; after release, in_ready=1 and a late data_ok is ignored.
- With MEM_MISALIGN_TRAP_EN: load half at alu_out=0x3001 -> no dreq_valid; next cycle out_valid=1, out_exc=1, out_regwrite=0.
